// File: rtl/sha256_digest_reader.sv
// sha256_digest_reader: captures the hash core's digest on the rising edge of
// trigger, compares it against a reference digest, then streams it out as
// NUM_WORDS words over valid/ready, most significant word (H0) first.
// DIGEST_BITS must equal NUM_WORDS * WORD_BITS.

module sha256_digest_reader #(
  parameter int unsigned DIGEST_BITS = 256,
  parameter int unsigned WORD_BITS   = 32,
  parameter int unsigned NUM_WORDS   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger,
  input  logic [DIGEST_BITS-1:0] H_in,
  input  logic [DIGEST_BITS-1:0] expected,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_BITS-1:0]   out_data,
  output logic                   out_last,
  output logic                   match,
  output logic                   match_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 state_q, state_d;
  logic                   trig_q;
  logic [DIGEST_BITS-1:0] shadow_q, shadow_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   match_q, match_d;
  logic                   match_valid_q, match_valid_d;
  logic                   overrun_q, overrun_d;

  logic trig_rise;
  logic sending;
  logic handshake;
  logic last_handshake;
  logic capture;

  // Shadow register viewed as an array of output words, word 0 = MSW.
  logic [WORD_BITS-1:0] words [NUM_WORDS];

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_words
    assign words[i] = shadow_q[DIGEST_BITS-1-WORD_BITS*i -: WORD_BITS];
  end

  // Edge detect and handshake qualifiers.
  always_comb begin
    trig_rise      = trigger & ~trig_q;
    sending        = (state_q == StSend);
    handshake      = sending & out_ready;
    last_handshake = handshake & (idx_q == LastIdx);
    // A new digest is taken when idle, or in the very cycle the last word leaves.
    capture        = trig_rise & (~sending | last_handshake);
  end

  // Next-state logic for the FSM, word index, shadow and status flags.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    idx_d         = idx_q;
    match_d       = match_q;
    match_valid_d = match_valid_q;
    overrun_d     = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (last_handshake) begin
          state_d = capture ? StSend : StIdle;
          idx_d   = '0;
        end else if (handshake) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      shadow_d      = H_in;
      // Compare the live input so match is ready together with the first word.
      match_d       = (H_in == expected);
      match_valid_d = 1'b1;
      idx_d         = '0;
    end

    // An edge that cannot be captured is dropped and flagged.
    if (trig_rise && sending && !last_handshake) begin
      overrun_d = 1'b1;
    end
  end

  // State registers; trig_q resets high so a trigger already high at release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      trig_q        <= 1'b1;
      shadow_q      <= '0;
      idx_q         <= '0;
      match_q       <= 1'b0;
      match_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_q        <= trigger;
      shadow_q      <= shadow_d;
      idx_q         <= idx_d;
      match_q       <= match_d;
      match_valid_q <= match_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  // Outputs are decoded from registered state only; out_ready never reaches out_valid.
  always_comb begin
    out_valid   = sending;
    busy        = sending;
    out_data    = words[idx_q];
    out_last    = sending & (idx_q == LastIdx);
    match       = match_q;
    match_valid = match_valid_q;
    overrun     = overrun_q;
  end

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Directed bench for sha256_digest_reader with a word scoreboard.
module tb_sha256_digest_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         trigger;
  logic [255:0] H_in;
  logic [255:0] expected;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         match;
  logic         match_valid;
  logic         busy;
  logic         overrun;

  localparam logic [255:0] Abc =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] Empty =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  int compared   = 0;
  int mismatched = 0;
  int n_xfer     = 0;
  logic hs_flag;
  logic [32:0] exp_q [$];

  sha256_digest_reader dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .H_in        (H_in),
    .expected    (expected),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .match       (match),
    .match_valid (match_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_digest(input logic [255:0] d);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({(i == 7), d[255-32*i -: 32]});
    end
  endtask

  // Drive inputs just after the falling edge, then score any transfer due at the next rise.
  task automatic cycle(input logic rdy, input logic trig);
    logic [32:0] e;
    @(negedge clk);
    out_ready = rdy;
    trigger   = trig;
    #1;
    hs_flag = out_valid && out_ready;
    if (hs_flag) begin
      n_xfer++;
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL sb_extra: observed word %h expected no word", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_data", out_data, e[31:0]);
        check("sb_last", {31'd0, out_last}, {31'd0, e[32]});
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    trigger   = 1'b1;
    out_ready = 1'b0;
    H_in      = '0;
    expected  = '0;

    // 1: reset state, trigger high at release is not an edge
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_match", {31'd0, match}, 32'd0);
    check("rst_mvalid", {31'd0, match_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    H_in     = Abc;
    expected = Abc;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    check("rel_no_capture", {31'd0, out_valid}, 32'd0);

    // 2: "abc" vector, full rate
    cycle(1'b1, 1'b0);
    push_digest(Abc);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
      check("abc_consec", {31'd0, hs_flag}, 32'd1);
      if (i == 0) begin
        check("abc_match", {31'd0, match}, 32'd1);
        check("abc_mvalid", {31'd0, match_valid}, 32'd1);
        check("abc_busy", {31'd0, busy}, 32'd1);
      end
    end
    cycle(1'b1, 1'b0);
    check("abc_done_valid", {31'd0, out_valid}, 32'd0);
    check("abc_done_busy", {31'd0, busy}, 32'd0);
    check("abc_sb_empty", exp_q.size(), 32'd0);

    // 3: backpressure at word 2, then random ready
    push_digest(Abc);
    cycle(1'b1, 1'b1);
    n_xfer = 0;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      check("stall_data", out_data, 32'h414140de);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    for (int g = 0; g < 200 && n_xfer < 8; g++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0);
    end
    check("bp_xfers", n_xfer, 32'd8);
    cycle(1'b1, 1'b0);
    check("bp_no_dup", n_xfer, 32'd8);
    check("bp_sb_empty", exp_q.size(), 32'd0);

    // 4: mismatching reference
    expected = Abc ^ 256'd1;
    push_digest(Abc);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 0) begin
        check("mis_match", {31'd0, match}, 32'd0);
        check("mis_mvalid", {31'd0, match_valid}, 32'd1);
      end
    end
    check("mis_sb_empty", exp_q.size(), 32'd0);
    expected = Abc;
    cycle(1'b1, 1'b0);

    // 5a: edge coincident with the last handshake restarts the stream
    push_digest(Abc);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
    H_in = Empty;
    push_digest(Empty);
    cycle(1'b1, 1'b1);
    check("coin_last_hs", {31'd0, hs_flag}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
      check("coin_consec", {31'd0, hs_flag}, 32'd1);
    end
    check("coin_overrun", {31'd0, overrun}, 32'd0);
    check("coin_match", {31'd0, match}, 32'd0);
    check("coin_sb_empty", exp_q.size(), 32'd0);

    // 5b: edge while streaming word 3 is dropped and flagged
    H_in = Abc;
    push_digest(Abc);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    H_in = Empty;
    cycle(1'b0, 1'b1);
    check("ovr_held_data", out_data, 32'h5dae2223);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 0) check("ovr_flag", {31'd0, overrun}, 32'd1);
    end
    check("ovr_match_kept", {31'd0, match}, 32'd1);
    check("ovr_sb_empty", exp_q.size(), 32'd0);
    cycle(1'b1, 1'b0);
    check("ovr_idle", {31'd0, busy}, 32'd0);

    // 6: asynchronous reset mid-stream, then a fresh stream from word 0
    H_in = Abc;
    push_digest(Abc);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_mvalid", {31'd0, match_valid}, 32'd0);
    check("arst_overrun", {31'd0, overrun}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0);
    check("arst_no_resume", {31'd0, out_valid}, 32'd0);
    push_digest(Abc);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
      check("arst_consec", {31'd0, hs_flag}, 32'd1);
    end
    check("arst_sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
